// File: rtl/reaction_timer.sv
// Reaction timer: captures a random delay, counts it down in ms, lights GO, then times the press.
// Optional best-time tracking is enabled with `define REACTION_BEST_TIME_EN.
module reaction_timer #(
    parameter int CLKS_PER_MS  = 50000,
    parameter int MAX_REACT_MS = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_btn,
    input  logic [12:0] i_randomNum,
    output logic        o_pause,
    output logic        o_led,
    output logic [13:0] o_reactMs,
    output logic        o_done,
    output logic        o_foul,
    output logic        o_timeout,
    output logic        o_busy
`ifdef REACTION_BEST_TIME_EN
    ,
    output logic [13:0] o_bestMs
`endif
);

    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(CLKS_PER_MS - 1);
    localparam logic [13:0] REACT_MAX = 14'(MAX_REACT_MS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_GO      = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_FOUL    = 3'd4;
    localparam logic [2:0] S_TIMEOUT = 3'd5;

    logic [2:0]    state, state_nxt;
    logic [PW-1:0] prescaler;
    logic [12:0]   delay_ms;
    logic [13:0]   react_cnt;
    logic [13:0]   react_inc;
    logic          btn_q;
    logic          press;
    logic          tick;
    logic          can_start;

    assign press     = i_btn & ~btn_q;
    assign tick      = (prescaler == PS_MAX);
    assign react_inc = react_cnt + 14'd1;
    assign can_start = i_start & (state != S_WAIT) & (state != S_GO);

    // Strobe is combinational so the generator freezes in the very cycle we sample it.
    assign o_pause = can_start & ~rst;
    assign o_led   = (state == S_GO);
    assign o_busy  = (state == S_WAIT) | (state == S_GO);

    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: begin
                if (press)
                    state_nxt = S_FOUL;
                else if (delay_ms == 13'd0 || (tick && delay_ms <= 13'd1))
                    state_nxt = S_GO;
            end
            S_GO: begin
                if (press)
                    state_nxt = S_DONE;
                else if (tick && react_inc == REACT_MAX)
                    state_nxt = S_TIMEOUT;
            end
            default: begin
                if (i_start)
                    state_nxt = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            prescaler <= '0;
            delay_ms  <= '0;
            react_cnt <= '0;
            btn_q     <= 1'b0;
            o_reactMs <= '0;
            o_done    <= 1'b0;
            o_foul    <= 1'b0;
            o_timeout <= 1'b0;
`ifdef REACTION_BEST_TIME_EN
            o_bestMs  <= 14'h3FFF;
`endif
        end else begin
            btn_q <= i_btn;
            state <= state_nxt;
            // Restart the ms prescaler on every state change so each phase is whole ticks long.
            if (state_nxt != state || tick)
                prescaler <= '0;
            else
                prescaler <= prescaler + PW'(1);

            case (state)
                S_WAIT: begin
                    if (press)
                        o_foul <= 1'b1;
                    else if (tick && delay_ms > 13'd1)
                        delay_ms <= delay_ms - 13'd1;
                end
                S_GO: begin
                    if (press) begin
                        o_reactMs <= react_cnt;
                        o_done    <= 1'b1;
`ifdef REACTION_BEST_TIME_EN
                        if (react_cnt < o_bestMs)
                            o_bestMs <= react_cnt;
`endif
                    end else if (tick) begin
                        react_cnt <= react_inc;
                        if (react_inc == REACT_MAX) begin
                            o_reactMs <= REACT_MAX;
                            o_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (i_start) begin
                        delay_ms  <= i_randomNum;
                        react_cnt <= '0;
                        o_reactMs <= '0;
                        o_done    <= 1'b0;
                        o_foul    <= 1'b0;
                        o_timeout <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
